prio_enc_rr: RTL and testbench
==============================

Name: prio_enc_rr

Overview:
- Parametrised, registered priority encoder for N request lines.
- Two modes: fixed priority, where bit 0 is highest; and round-robin priority, which rotates from the last grant.
- Result sits in a one-entry output stage with a valid/ready handshake.
- Used wherever a datapath picks one of N requesters per transaction (arbiter front-ends, interrupt selection).

Parameters:
- N, 8, number of request lines; legal range 2..64, need not be a power of two.
- IDX_W, 3, index width; must equal ceil(log2(N)).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request vector valid
- in_ready  out  1  block can accept this cycle
- req  in  N  request vector; bit k = requester k
- mode  in  1  0 = fixed LSB-first, 1 = round-robin; sampled on accept
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes the result
- out_idx  out  IDX_W  selected requester index
- out_onehot  out  N  one-hot of out_idx; all-zero when out_any=0
- out_any  out  1  1 if the accepted req was nonzero

Behaviour:
- Reset (rst=1 at an edge) sets:
  - out_valid=0, out_idx=0, out_onehot=0, out_any=0.
  - Round-robin pointer ptr=0.
  - Any held result is discarded.
  - rst overrides every other input in that cycle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency: 1 cycle. Results from req accepted at edge t appear with out_valid=1 after edge t.
- Throughput: one result per cycle when out_ready is held 1.
- Simultaneous transfer and accept: the new result replaces the old one and out_valid stays 1.
- Transfer without accept: out_valid goes to 0.
- While out_valid=1 and out_ready=0:
  - out_idx, out_onehot and out_any are held stable.
  - in_ready=0; req changes are ignored.
- Fixed mode (mode=0): out_idx = lowest set bit index of req.
- Round-robin mode (mode=1):
  - Search starts at index ptr and moves upward, wrapping from N-1 to 0.
  - First set bit wins.
- Zero request vector (req=0, either mode):
  - out_any=0, out_onehot=0, out_idx=N-1 (legacy-compatible all-zero code).
  - ptr is unchanged.
- Pointer update, only on accept with mode=1 and req!=0:
  - ptr <= (out_idx == N-1) ? 0 : out_idx+1.
  - Wrap is explicit, so non-power-of-two N never yields an index >= N.
- Fixed-mode accepts never change ptr. Switching mode takes effect on the next accept; ptr keeps its value across mode switches.
- No FSM beyond the out_valid flag and the ptr register.
- Index arithmetic is unsigned, IDX_W bits.
- Outputs never take X after reset for any legal inputs.

Optional Feature:
- Macro: PRIO_ENC_COUNT_EN.
- With the macro defined:
  - Adds output port out_cnt (out, IDX_W+1 bits) = popcount of the accepted req.
  - out_cnt is registered with the other outputs, held under backpressure, and reset to 0.
- Without the macro: port absent; logic and timing of all other outputs are identical.

Test Plan:
- N=8, mode=0, req=8'b0010_1100, out_ready=1 -> next cycle out_valid=1, out_idx=2, out_onehot=8'b0000_0100, out_any=1; with feature, out_cnt=3.
- N=8, mode=0, req=8'h00 -> out_idx=7, out_onehot=0, out_any=0. Then mode=1, req=8'h00 -> ptr unchanged (still 0).
- N=8, mode=1, req=8'hFF for 10 back-to-back accepts with out_ready=1 -> out_idx sequence 0,1,2,3,4,5,6,7,0,1.
- N=5, mode=1, req=5'b10001 with ptr=1 -> out_idx=4, then next accept out_idx=0 (wrap), then out_idx=4.
- Backpressure: out_ready=0 for 3 cycles after a result of idx=2 while req changes -> in_ready=0, out_idx stays 2. Release -> next accepted req reflects ptr=3.
- Reset mid-stream: rst=1 while out_valid=1, out_ready=0, ptr=5 -> next cycle out_valid=0, outputs 0. Then mode=1, req=8'hFF -> out_idx=0.

Source files
------------

// File: rtl/prio_enc_rr.sv
// prio_enc_rr: registered N-input priority encoder with a one-entry
// valid/ready output stage. Two selection modes, picked per accept:
//   mode=0  fixed priority, bit 0 highest
//   mode=1  round-robin, search starts at ptr and wraps N-1 -> 0
// Optional feature macro: PRIO_ENC_COUNT_EN adds out_cnt, the popcount of
// the accepted request vector, registered alongside the other outputs.
module prio_enc_rr #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     req,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             out_any
`ifdef PRIO_ENC_COUNT_EN
  ,
  output logic [IDX_W:0]   out_cnt
`endif
);

  // Index reported for an empty request vector; kept at N-1 because
  // downstream consumers historically decode this as "nothing selected".
  localparam logic [IDX_W-1:0] IDX_EMPTY = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [N-1:0]     ONE_N     = {{(N-1){1'b0}}, 1'b1};

  // Lowest set bit of vec, or IDX_EMPTY when vec is all zero. Scanning from
  // the top down lets the last hit (the lowest index) win without a flag.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = IDX_EMPTY;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

`ifdef PRIO_ENC_COUNT_EN
  // Number of set bits; IDX_W+1 bits holds N even when N is a power of two.
  function automatic logic [IDX_W:0] popcount(input logic [N-1:0] vec);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction
`endif

  // State
  logic             out_valid_reg;
  logic [IDX_W-1:0] out_idx_reg;
  logic [N-1:0]     out_onehot_reg;
  logic             out_any_reg;
  logic [IDX_W-1:0] ptr_reg;
`ifdef PRIO_ENC_COUNT_EN
  logic [IDX_W:0]   out_cnt_reg;
`endif

  // Combinational selection
  logic [N-1:0]     rr_mask;
  logic [N-1:0]     req_masked;
  logic [N-1:0]     sel_vec;
  logic [IDX_W-1:0] idx_next;
  logic [N-1:0]     onehot_next;
  logic             any_next;
  logic [IDX_W-1:0] ptr_next;
  logic             accept;

  // Round-robin window: requesters at or above the pointer get first chance.
  // Only indices below N exist, so the mask never admits an illegal index.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rr_mask
      assign rr_mask[gi] = (IDX_W'(gi) >= ptr_reg);
    end
  endgenerate

  assign req_masked = req & rr_mask;
  assign accept     = in_valid && in_ready;
  assign in_ready   = !out_valid_reg || out_ready;

  // Pick the vector to encode: in round-robin mode, if nothing sits at or
  // above ptr, the search wraps, which is the same as encoding the full req.
  always_comb begin
    sel_vec = req;
    if (mode && (|req_masked)) begin
      sel_vec = req_masked;
    end
  end

  // Encode the selection and derive the matching one-hot and pointer advance.
  always_comb begin
    any_next    = |req;
    idx_next    = lowest_idx(sel_vec);
    onehot_next = '0;
    if (any_next) begin
      onehot_next = ONE_N << idx_next;
    end
    // Explicit wrap so a non-power-of-two N never steps past N-1.
    ptr_next = (idx_next == IDX_LAST) ? '0 : idx_next + IDX_W'(1);
  end

  // Output stage: load on accept, drop valid on a transfer with no refill,
  // otherwise hold everything (covers backpressure).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_idx_reg    <= '0;
      out_onehot_reg <= '0;
      out_any_reg    <= 1'b0;
`ifdef PRIO_ENC_COUNT_EN
      out_cnt_reg    <= '0;
`endif
    end else if (accept) begin
      out_valid_reg  <= 1'b1;
      out_idx_reg    <= idx_next;
      out_onehot_reg <= onehot_next;
      out_any_reg    <= any_next;
`ifdef PRIO_ENC_COUNT_EN
      out_cnt_reg    <= popcount(req);
`endif
    end else if (out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  // Round-robin pointer: advances only on round-robin accepts that granted
  // something; fixed-mode and empty accepts leave it where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (accept && mode && any_next) begin
      ptr_reg <= ptr_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_idx    = out_idx_reg;
  assign out_onehot = out_onehot_reg;
  assign out_any    = out_any_reg;
`ifdef PRIO_ENC_COUNT_EN
  assign out_cnt    = out_cnt_reg;
`endif

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed testbench for prio_enc_rr: one 8-input instance for the main
// scenarios and a 5-input instance for non-power-of-two wrap behaviour.
module tb_prio_enc_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=8 instance
  logic       in_valid, in_ready, mode, out_valid, out_ready, out_any;
  logic [7:0] req, out_onehot;
  logic [2:0] out_idx;
`ifdef PRIO_ENC_COUNT_EN
  logic [3:0] out_cnt;
`endif

  // N=5 instance
  logic       b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_out_any;
  logic [4:0] b_req, b_out_onehot;
  logic [2:0] b_out_idx;
`ifdef PRIO_ENC_COUNT_EN
  logic [3:0] b_out_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  prio_enc_rr #(.N(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .req(req), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_onehot(out_onehot), .out_any(out_any)
`ifdef PRIO_ENC_COUNT_EN
    , .out_cnt(out_cnt)
`endif
  );

  prio_enc_rr #(.N(5), .IDX_W(3)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .req(b_req), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_idx(b_out_idx), .out_onehot(b_out_onehot), .out_any(b_out_any)
`ifdef PRIO_ENC_COUNT_EN
    , .out_cnt(b_out_cnt)
`endif
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    $display("txn %0d: v=%b idx=%0d oh=%b any=%b | n5 v=%b idx=%0d oh=%b",
             cycle, out_valid, out_idx, out_onehot, out_any,
             b_out_valid, b_out_idx, b_out_onehot);
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; req = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_mode = 1'b0; b_req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", out_idx); end
    checks++; if (out_onehot !== 8'h00) begin errors++; $display("FAIL reset_onehot: got %h expected 00", out_onehot); end
    checks++; if (out_any !== 1'b0) begin errors++; $display("FAIL reset_any: got %b expected 0", out_any); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fixed();
    apply_reset();
    in_valid = 1'b1; mode = 1'b0; req = 8'b0010_1100;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid: got %b expected 1", out_valid); end
    checks++; if (out_idx !== 3'd2) begin errors++; $display("FAIL fixed_idx: got %0d expected 2", out_idx); end
    checks++; if (out_onehot !== 8'b0000_0100) begin errors++; $display("FAIL fixed_onehot: got %b expected 00000100", out_onehot); end
    checks++; if (out_any !== 1'b1) begin errors++; $display("FAIL fixed_any: got %b expected 1", out_any); end
`ifdef PRIO_ENC_COUNT_EN
    checks++; if (out_cnt !== 4'd3) begin errors++; $display("FAIL fixed_cnt: got %0d expected 3", out_cnt); end
`endif
    req = 8'h80;
    step();
    checks++; if (out_idx !== 3'd7 || out_onehot !== 8'h80 || out_any !== 1'b1) begin errors++; $display("FAIL fixed_top: got idx=%0d oh=%h any=%b expected idx=7 oh=80 any=1", out_idx, out_onehot, out_any); end
    req = 8'h00;
    step();
    checks++; if (out_idx !== 3'd7 || out_onehot !== 8'h00 || out_any !== 1'b0) begin errors++; $display("FAIL fixed_zero: got idx=%0d oh=%h any=%b expected idx=7 oh=00 any=0", out_idx, out_onehot, out_any); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_zero_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_zero_ptr();
    apply_reset();
    in_valid = 1'b1; mode = 1'b1; req = 8'h00;
    step();
    checks++; if (out_idx !== 3'd7 || out_any !== 1'b0 || out_onehot !== 8'h00) begin errors++; $display("FAIL rr_zero: got idx=%0d oh=%h any=%b expected idx=7 oh=00 any=0", out_idx, out_onehot, out_any); end
    req = 8'hFF;
    step();
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL rr_zero_ptr_kept: got %0d expected 0", out_idx); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_idx;
    apply_reset();
    in_valid = 1'b1; mode = 1'b1; req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_idx = 3'(i % 8);
      checks++; if (out_idx !== exp_idx || out_valid !== 1'b1) begin errors++; $display("FAIL rr_sweep_%0d: got idx=%0d v=%b expected idx=%0d v=1", i, out_idx, out_valid, exp_idx); end
    end
  endtask

  task automatic test_mode_switch();
    apply_reset();
    in_valid = 1'b1; mode = 1'b1; req = 8'hFF;
    step();   // grant 0, ptr -> 1
    mode = 1'b0;
    step();   // fixed grant 0, ptr stays 1
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL switch_fixed: got %0d expected 0", out_idx); end
    mode = 1'b1;
    step();
    checks++; if (out_idx !== 3'd1) begin errors++; $display("FAIL switch_rr_ptr: got %0d expected 1", out_idx); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL transfer_no_accept: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    in_valid = 1'b1; mode = 1'b1; req = 8'h04;
    step();   // idx 2, ptr -> 3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = (i == 1) ? 8'h01 : 8'hF0;
      mode = (i == 2) ? 1'b0 : 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b expected 0", i, in_ready); end
      step();
      checks++; if (out_idx !== 3'd2 || out_onehot !== 8'h04 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_%0d: got idx=%0d oh=%h v=%b expected idx=2 oh=04 v=1", i, out_idx, out_onehot, out_valid); end
    end
    out_ready = 1'b1; mode = 1'b1; req = 8'hFF;
    step();
    checks++; if (out_idx !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_release: got idx=%0d v=%b expected idx=3 v=1", out_idx, out_valid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    in_valid = 1'b1; mode = 1'b1; req = 8'h10;
    step();   // idx 4, ptr -> 5
    out_ready = 1'b0; req = 8'hFF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_onehot !== 8'h00 || out_any !== 1'b0) begin errors++; $display("FAIL mid_reset: got v=%b idx=%0d oh=%h any=%b expected all 0", out_valid, out_idx, out_onehot, out_any); end
    out_ready = 1'b1; mode = 1'b1; req = 8'hFF;
    step();
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL mid_reset_ptr: got %0d expected 0", out_idx); end
  endtask

  task automatic test_n5_wrap();
    apply_reset();
    b_in_valid = 1'b1; b_mode = 1'b1; b_req = 5'b00001;
    step();   // idx 0, ptr -> 1
    b_req = 5'b10001;
    step();
    checks++; if (b_out_idx !== 3'd4 || b_out_onehot !== 5'b10000) begin errors++; $display("FAIL n5_first: got idx=%0d oh=%b expected idx=4 oh=10000", b_out_idx, b_out_onehot); end
    step();
    checks++; if (b_out_idx !== 3'd0 || b_out_onehot !== 5'b00001) begin errors++; $display("FAIL n5_wrap: got idx=%0d oh=%b expected idx=0 oh=00001", b_out_idx, b_out_onehot); end
    step();
    checks++; if (b_out_idx !== 3'd4) begin errors++; $display("FAIL n5_again: got %0d expected 4", b_out_idx); end
    b_req = 5'b00000;
    step();
    checks++; if (b_out_idx !== 3'd4 || b_out_any !== 1'b0 || b_out_onehot !== 5'b0) begin errors++; $display("FAIL n5_zero: got idx=%0d any=%b oh=%b expected idx=4 any=0 oh=00000", b_out_idx, b_out_any, b_out_onehot); end
    b_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_zero_ptr();
    test_back_to_back();
    test_mode_switch();
    test_backpressure();
    test_reset_mid();
    test_n5_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
